dual_ram_async: RTL and testbench



---
 rtl/dual_ram_async.sv | 63 ++++++
 tb/tb_dual_ram_async.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/dual_ram_async.sv
// dual_ram_async
//   Dual-port 1024 x 8 RAM, one clock, two independent read/write ports.
//   Writes land on the rising clock edge; reads are purely combinational
//   from the current address. An active-low asynchronous reset clears every
//   word immediately and blocks writes for as long as it is held.
//
// Ports
//   clk    in   1   rising-edge clock for all writes
//   rst_n  in   1   asynchronous active-low reset, clears the whole array
//   din1   in   8   port 1 write data
//   addr1  in  10   port 1 address (read and write)
//   w_en1  in   1   port 1 write enable, active high
//   dout1  out  8   port 1 read data = mem[addr1]
//   din2   in   8   port 2 write data
//   addr2  in  10   port 2 address (read and write)
//   w_en2  in   1   port 2 write enable, active high
//   dout2  out  8   port 2 read data = mem[addr2]
//
// There is no handshake: a write is accepted on every rising edge where the
// port's w_en is high and rst_n is high; reads are always valid.

module dual_ram_async (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din1,
  input  logic [9:0] addr1,
  input  logic       w_en1,
  output logic [7:0] dout1,
  input  logic [7:0] din2,
  input  logic [9:0] addr2,
  input  logic       w_en2,
  output logic [7:0] dout2
);

  localparam int DEPTH = 1024;

  logic [7:0] mem [DEPTH];

  // Whole-array clear on reset means this is built from flops rather than a
  // RAM macro; that is what makes the immediate asynchronous clear possible.
  // Port 2 is written first so that, when both ports hit the same word on
  // the same edge, the later port 1 assignment is the one that sticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else begin
      if (w_en2) begin
        mem[addr2] <= din2;
      end
      if (w_en1) begin
        mem[addr1] <= din1;
      end
    end
  end

  // Zero-latency reads: dout follows both address and array contents, so a
  // word written on an edge is visible on either port right after that edge.
  assign dout1 = mem[addr1];
  assign dout2 = mem[addr2];

endmodule

// File: tb/tb_dual_ram_async.sv
module tb_dual_ram_async;

  logic       clk;
  logic       rst_n;
  logic [7:0] din1;
  logic [9:0] addr1;
  logic       w_en1;
  logic [7:0] dout1;
  logic [7:0] din2;
  logic [9:0] addr2;
  logic       w_en2;
  logic [7:0] dout2;

  int n_compared;
  int n_mismatched;

  dual_ram_async dut (
    .clk   (clk),
    .rst_n (rst_n),
    .din1  (din1),
    .addr1 (addr1),
    .w_en1 (w_en1),
    .dout1 (dout1),
    .din2  (din2),
    .addr2 (addr2),
    .w_en2 (w_en2),
    .dout2 (dout2)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d (0x%02h), expected %0d (0x%02h)", tag, obs, obs, exp, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // One write cycle: inputs set on the falling edge, committed on the rising
  // edge, enables dropped 1 ns after it.
  task automatic write_cycle(input logic we1, input logic [9:0] a1, input logic [7:0] d1,
                             input logic we2, input logic [9:0] a2, input logic [7:0] d2);
    @(negedge clk);
    w_en1 = we1; addr1 = a1; din1 = d1;
    w_en2 = we2; addr2 = a2; din2 = d2;
    @(posedge clk);
    #1;
    w_en1 = 1'b0;
    w_en2 = 1'b0;
  endtask

  task automatic write1(input logic [9:0] a, input logic [7:0] d);
    write_cycle(1'b1, a, d, 1'b0, 10'd0, 8'd0);
  endtask

  // Set both read addresses and let the combinational path settle.
  task automatic read_both(input logic [9:0] a1, input logic [9:0] a2);
    addr1 = a1;
    addr2 = a2;
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst_n = 1'b0;
    din1 = 8'd0; addr1 = 10'd0; w_en1 = 1'b0;
    din2 = 8'd0; addr2 = 10'd0; w_en2 = 1'b0;

    // Reset: array reads zero everywhere we look.
    #2;
    read_both(10'd0, 10'd0);
    check("rst_dout1_a0", dout1, 8'h00);
    check("rst_dout2_a0", dout2, 8'h00);
    read_both(10'd1001, 10'd1001);
    check("rst_dout1_a1001", dout1, 8'h00);
    check("rst_dout2_a1001", dout2, 8'h00);
    read_both(10'd1023, 10'd1023);
    check("rst_dout1_a1023", dout1, 8'h00);
    check("rst_dout2_a1023", dout2, 8'h00);

    // Write attempt during reset is ignored.
    write_cycle(1'b1, 10'd1001, 8'hFF, 1'b1, 10'd1023, 8'hFF);
    read_both(10'd1001, 10'd1023);
    check("rst_write_ignored_p1", dout1, 8'h00);
    check("rst_write_ignored_p2", dout2, 8'h00);

    @(negedge clk);
    rst_n = 1'b1;

    // Independent writes on one edge, then cross-read.
    write_cycle(1'b1, 10'd1001, 8'd210, 1'b1, 10'd1010, 8'd210);
    read_both(10'd1010, 10'd1001);
    check("cross_dout1_a1010", dout1, 8'd210);
    check("cross_dout2_a1001", dout2, 8'd210);

    // Overwrite sequence.
    write1(10'd999, 8'd110);
    read_both(10'd999, 10'd999);
    check("ovw_first_a999", dout2, 8'd110);
    write1(10'd777, 8'd109);
    write1(10'd999, 8'd100);
    write1(10'd1000, 8'd140);
    read_both(10'd999, 10'd1000);
    check("ovw_dout1_a999", dout1, 8'd100);
    check("ovw_dout2_a1000", dout2, 8'd140);
    read_both(10'd777, 10'd1000);
    check("ovw_dout1_a777", dout1, 8'd109);

    // Collision: port 1 wins.
    write_cycle(1'b1, 10'd244, 8'd178, 1'b1, 10'd244, 8'd220);
    read_both(10'd244, 10'd244);
    check("coll_dout1_a244", dout1, 8'd178);
    check("coll_dout2_a244", dout2, 8'd178);

    // Different addresses on one edge both land.
    write_cycle(1'b1, 10'd123, 8'd33, 1'b1, 10'd456, 8'd66);
    read_both(10'd123, 10'd456);
    check("dual_dout1_a123", dout1, 8'd33);
    check("dual_dout2_a456", dout2, 8'd66);

    // Asynchronous read: addr1 steps with no clock edge in between.
    write_cycle(1'b1, 10'd336, 8'd11, 1'b1, 10'd567, 8'd22);
    @(negedge clk);
    addr1 = 10'd336; #1;
    check("async_a336", dout1, 8'd11);
    addr1 = 10'd567; #1;
    check("async_a567", dout1, 8'd22);
    addr1 = 10'd123; #1;
    check("async_a123", dout1, 8'd33);

    // Read-during-write: old value before the edge, new value after it,
    // on both the writing port and the observing port.
    @(negedge clk);
    addr1 = 10'd446;
    addr2 = 10'd446; din2 = 8'd250; w_en2 = 1'b1;
    #1;
    check("rdw_before_dout1", dout1, 8'h00);
    check("rdw_before_dout2", dout2, 8'h00);
    @(posedge clk);
    #1;
    w_en2 = 1'b0;
    check("rdw_after_dout1", dout1, 8'd250);
    check("rdw_after_dout2", dout2, 8'd250);

    // Reset mid-operation clears without a clock edge.
    write1(10'd888, 8'd77);
    read_both(10'd999, 10'd888);
    check("pre_rst_a999", dout1, 8'd100);
    check("pre_rst_a888", dout2, 8'd77);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_dout1", dout1, 8'h00);
    check("mid_rst_dout2", dout2, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after release performs a normal write.
    write_cycle(1'b0, 10'd0, 8'd0, 1'b1, 10'd446, 8'd250);
    read_both(10'd446, 10'd999);
    check("post_rst_a446", dout1, 8'd250);
    check("post_rst_a999", dout2, 8'h00);
    read_both(10'd888, 10'd244);
    check("post_rst_a888", dout1, 8'h00);
    check("post_rst_a244", dout2, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
